// File: rtl/rr_mux_arbiter_pkg.sv
// Shared types and constants for the 4-requester round-robin mux arbiter.
package rr_mux_arbiter_pkg;

  localparam int NREQ = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

endpackage

// File: rtl/rr_mux_arbiter_mux4_w.sv
// Combinational 4:1 data mux with a 2-bit select.
module mux4_w #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] d0_i,
  input  logic [WIDTH-1:0] d1_i,
  input  logic [WIDTH-1:0] d2_i,
  input  logic [WIDTH-1:0] d3_i,
  input  logic [1:0]       sel_i,
  output logic [WIDTH-1:0] y_o
);

  always_comb begin
    y_o = d0_i;
    case (sel_i)
      2'd0: y_o = d0_i;
      2'd1: y_o = d1_i;
      2'd2: y_o = d2_i;
      2'd3: y_o = d3_i;
      default: y_o = d0_i;
    endcase
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter for 4 requesters driving a shared valid/ready output port.
module rr_mux_arbiter
  import rr_mux_arbiter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic [WIDTH-1:0] in4,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       op,
  output logic [NREQ-1:0]  ack,
  output state_e           dbg_state
);

  // Handshake: a transfer happens in a cycle where out_valid && out_ready and
  // req[op] is still high; a requester dropping req[op] withdraws its offer
  // (abort) even if out_ready is high in that same cycle.

  state_e           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] mux_data;
  logic [2:0]       pick_idle;
  logic [2:0]       pick_next;
  logic [NREQ-1:0]  req_masked;

  // Returns {found, index}: first set bit of r at or after start, cyclically.
  function automatic logic [2:0] rr_pick(input logic [NREQ-1:0] r,
                                         input logic [1:0]      start);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = start + 2'(k);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign req_masked = req & ~(NREQ'(1) << op_q);
  assign pick_idle  = rr_pick(req, ptr_q);
  assign pick_next  = rr_pick(req_masked, op_q + 2'd1);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    op_d    = op_q;
    ack     = '0;
    case (state_q)
      IDLE: begin
        if (pick_idle[2]) begin
          op_d    = pick_idle[1:0];
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (!req[op_q]) begin
          state_d = IDLE;
        end else if (out_ready) begin
          ack[op_q] = 1'b1;
          ptr_d     = op_q + 2'd1;
          if (pick_next[2]) begin
            op_d = pick_next[1:0];
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      op_q    <= 2'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      op_q    <= op_d;
    end
  end

  mux4_w #(.WIDTH(WIDTH)) u_mux (
    .d0_i  (in1),
    .d1_i  (in2),
    .d2_i  (in3),
    .d3_i  (in4),
    .sel_i (op_q),
    .y_o   (mux_data)
  );

  assign out_valid = (state_q == GRANT);
  assign out_data  = out_valid ? mux_data : '0;
  assign op        = op_q;
  assign dbg_state = state_q;

endmodule

// File: doc/rr_mux_arbiter.md
RR_MUX_ARBITER -- requirements
Module: rr_mux_arbiter

Interface
REQ-001 The block SHALL have one parameter, WIDTH, default 32, giving the datapath width in bits; the requester count SHALL be fixed at 4.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 req  in  4  per-requester request; bit i is held high until ack[i] or abort.
REQ-006 in1, in2, in3, in4  in  WIDTH each  requester 0..3 data, stable while its req is high.
REQ-007 out_valid  out  1  output data is valid.
REQ-008 out_ready  in  1  consumer accepts; a transfer occurs when out_valid && out_ready.
REQ-009 out_data  out  WIDTH  granted requester's data when out_valid=1, else all zeros.
REQ-010 op  out  2  index of the current or last granted requester (mux select).
REQ-011 ack  out  4  one-hot pulse, combinational, high in the transfer cycle only.

Function
REQ-012 The FSM SHALL have two states: IDLE (out_valid=0) and GRANT (out_valid=1).
REQ-013 In IDLE with req!=0, the block SHALL pick the first set bit at or after ptr, in cyclic order 0,1,2,3,0.
  - It SHALL load op with that index and enter GRANT on the next edge.
  - Latency from req to out_valid SHALL be one cycle.
REQ-014 In GRANT, out_data SHALL equal in(op+1) combinationally (op=0 -> in1 ... op=3 -> in4).
REQ-015 In GRANT with out_ready=0 and req[op]=1, op, out_valid and out_data SHALL hold, and ack SHALL be 0.
REQ-016 On a transfer, the block SHALL assert ack[op]=1 for that cycle and load ptr with (op+1) mod 4 (3 wraps to 0).
REQ-017 On a transfer, the block SHALL re-arbitrate in the same cycle over req with bit op masked, starting at (op+1) mod 4.
  - If any bit remains, it SHALL stay in GRANT with the new op, with no bubble.
  - Otherwise it SHALL go to IDLE.
REQ-018 Abort: in GRANT with req[op]=0 and no transfer, the block SHALL go to IDLE with no ack, and ptr SHALL be unchanged.
REQ-019 If req[op] falls in the same cycle as out_ready=1, it SHALL be treated as an abort; the transfer SHALL NOT occur.
REQ-020 out_ready while out_valid=0 SHALL be ignored.
REQ-021 In IDLE, op SHALL retain its last value; ack SHALL be 4'b0000 whenever no transfer occurs.
REQ-022 At most one ack bit SHALL ever be high.

Reset
REQ-023 On rst_n=0, at any time including mid-GRANT, the block SHALL immediately force:
  - state=IDLE, ptr=0, op=0;
  - out_valid=0, out_data=0, ack=0.
REQ-024 After rst_n rises, the first arbitration SHALL start with requester 0 as highest priority.

Structure
REQ-025 The shared package SHALL hold the state enum (IDLE, GRANT) and the constant NREQ=4.
REQ-026 The data mux SHALL be one sub-module, mux4_w: WIDTH-parameterised, 4 inputs, 2-bit select, combinational.
REQ-027 Round-robin pick logic SHALL be a function in the block; no other sub-modules SHALL exist.

Verification (in1=0, in2=1, in3=2, in4=3, WIDTH=32)
REQ-028 Single request: req=0100, out_ready=1 -> next cycle out_valid=1, op=2, out_data=2, ack=0100; then IDLE with out_data=0.
REQ-029 Fairness: req=1111 held, out_ready=1 -> op sequence 0,1,2,3,0 on consecutive cycles, out_data 0,1,2,3,0, out_valid never drops.
REQ-030 Backpressure: req=0010, out_ready=0 for 3 cycles then 1 -> op=1, out_data=1 stable for 4 cycles; ack=0010 only in the 4th.
REQ-031 Abort: req=0010 granted, req dropped to 0000 before out_ready -> IDLE, no ack; then req=1010 -> op=1 (ptr still 0).
REQ-032 Wrap: after a transfer with op=2, req=1001 -> op=3 then op=0.
REQ-033 Reset mid-GRANT: rst_n=0 while out_valid=1 -> out_valid, out_data, ack, op all 0 before the next clock edge.
